pattern_tx: RTL and testbench
=============================

# pattern_tx

Serial pattern transmitter: accepts a parallel word through a valid/ready load handshake, then drives it LSB-first onto a 1-bit serial line, one bit per enabled clock. It is the driving end of the serial DIN/DOUT interface consumed by `pattern_1011`, so a bench or link can stream words into the detector. It also counts overlapping `1011` occurrences in the emitted stream. The final count is the expected detector hit count for the cross-check.

## Interface
- `WIDTH`, 23: bits per loaded word; must be ≥ 4.
- `CNTW`, 5: width of `MATCH_COUNT`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `LOAD_VALID`  in  1  load request.
- `LOAD_DATA`  in  WIDTH  word to transmit; bit 0 is sent first.
- `LOAD_READY`  out  1  high only in IDLE.
- `SHIFT_EN`  in  1  advance enable; low holds the current bit on `DOUT`.
- `DOUT`  out  1  serial data; connects to the detector `DIN`.
- `DOUT_VALID`  out  1  high while `DOUT` carries a word bit.
- `DONE`  out  1  one-cycle pulse after the last bit.
- `MATCH_COUNT`  out  CNTW  overlapping `1011` matches (time order 1,0,1,1) in the current or last word.

## Operation
- FSM has three states:
  - IDLE → SHIFT on `LOAD_VALID && LOAD_READY`.
  - SHIFT → DONE when the last bit is consumed.
  - DONE → IDLE unconditionally.
- Accept actions: capture `LOAD_DATA` into the shift register, set bit index to 0, clear `MATCH_COUNT`, clear the 3-bit match history.
- No match spans two words.
- SHIFT behaviour:
  - `DOUT` = shift register bit 0 and `DOUT_VALID` = 1.
  - On an edge with `SHIFT_EN` = 1, the current bit is consumed: shift right by one, increment the index, push the bit into the history.
  - If history[2:0] plus the current bit equals 1,0,1,1 in time order, `MATCH_COUNT` increments, saturating at 2^CNTW−1.
  - With `SHIFT_EN` = 0, all state holds.
- Matches may overlap: stream 1,0,1,1,0,1,1 gives 2.
- Consuming bit WIDTH−1 moves the FSM to DONE.
- DONE: `DONE` = 1, `DOUT_VALID` = 0, `DOUT` = 0. `MATCH_COUNT` is final here.
- IDLE: `DOUT` = 0, `DOUT_VALID` = 0, `LOAD_READY` = 1. `MATCH_COUNT` holds its last value until the next accept.
- `LOAD_VALID` is ignored outside IDLE. `LOAD_DATA` is sampled only at accept.

## Timing
- Reset values (asynchronous assert, synchronous deassert by design):
  - state IDLE, `LOAD_READY` = 1;
  - `DOUT` = 0, `DOUT_VALID` = 0, `DONE` = 0, `MATCH_COUNT` = 0;
  - shift register and history cleared.
- Reset mid-word aborts the word immediately. No `DONE` pulse is produced.
- Accept at edge N: bit 0 is on `DOUT` from cycle N+1.
- With `SHIFT_EN` held high, bit k is on `DOUT` in cycle N+1+k.
- `DONE` is high in cycle N+1+WIDTH. `LOAD_READY` rises in cycle N+2+WIDTH.
- Minimum spacing between consecutive accepts is WIDTH+2 cycles.
- Each low cycle of `SHIFT_EN` during SHIFT delays every later event by one cycle.
- `MATCH_COUNT` updates on the same edge that consumes the completing bit.
- `DOUT` and `DOUT_VALID` are registered outputs, so the detector samples `DIN` glitch-free.

## Structure
- Package `pattern_pkg` holds:
  - `PATTERN` = 4'b1011, transmitted MSB-of-constant first (1,0,1,1);
  - `PAT_LEN` = 4;
  - `tx_state_t` enum {IDLE, SHIFT, DONE}.
- Sub-module `pattern_match_counter` (inputs: `bit`, `bit_valid`, `clear`; output: saturating count) holds the history and counter.
- The same sub-module is reusable as a golden model when checking `pattern_1011`.

## Test plan
- Reset, then idle 5 cycles → `LOAD_READY` = 1; `DOUT`, `DOUT_VALID`, `DONE`, `MATCH_COUNT` all 0.
- WIDTH=23, load 23'h59D8DB, `SHIFT_EN` = 1 → `DOUT` sequence 1,1,0,1,1,0,1,1,0,0,0,1,1,0,1,1,1,0,0,1,1,0,1; `DONE` 24 cycles after accept; `MATCH_COUNT` = 3.
- Load 23'h00006D (stream 1,0,1,1,0,1,1,0…) → `MATCH_COUNT` = 2 (overlap counted).
- Same word as the previous case, `SHIFT_EN` low every other cycle → identical bit sequence with each bit held 2 cycles; `DONE` at cycle 46 after accept; count unchanged.
- `LOAD_VALID` held high with a different word throughout → second accept only in the cycle after `LOAD_READY` rises; no corruption of the first word.
- Reset asserted at bit 10 → outputs return to reset values in the same cycle, no `DONE`; next load transmits cleanly from bit 0 with count restarted.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared constants and FSM state type for the serial pattern transmitter
// and its match counter.
package pattern_pkg;

  // Time order of the pattern is MSB of the constant first: 1,0,1,1.
  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         PAT_LEN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/pattern_match_counter.sv
// Counts overlapping occurrences of PATTERN in a qualified bit stream,
// saturating at the counter maximum; reusable as a golden detector model.
module pattern_match_counter
  import pattern_pkg::*;
#(
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bit_i,
  input  logic            bit_valid_i,
  input  logic            clear_i,
  output logic [CNTW-1:0] count_o
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [CNTW-1:0]    count_q, count_d;

  // Next history window and saturating count
  always_comb begin
    hist_d  = hist_q;
    count_d = count_q;
    if (clear_i) begin
      hist_d  = {(PAT_LEN-1){1'b0}};
      count_d = {CNTW{1'b0}};
    end else if (bit_valid_i) begin
      hist_d = {hist_q[PAT_LEN-3:0], bit_i};
      if (({hist_q, bit_i} == PATTERN) && (count_q != CNT_MAX)) begin
        count_d = count_q + CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end else begin
      hist_d  = hist_q;
      count_d = count_q;
    end
  end

  // History and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= {(PAT_LEN-1){1'b0}};
      count_q <= {CNTW{1'b0}};
    end else begin
      hist_q  <= hist_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: loads a word over valid/ready and emits it
// LSB-first on a registered serial line, counting 1011 matches on the way.
module pattern_tx
  import pattern_pkg::tx_state_t;
#(
  parameter int WIDTH = 23,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LOAD_VALID,
  input  logic [WIDTH-1:0] LOAD_DATA,
  output logic             LOAD_READY,
  input  logic             SHIFT_EN,
  output logic             DOUT,
  output logic             DOUT_VALID,
  output logic             DONE,
  output logic [CNTW-1:0]  MATCH_COUNT
);

  localparam int              IDXW     = $clog2(WIDTH);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = {{(IDXW-1){1'b0}}, 1'b1};

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             done_q, done_d;
  logic             accept_s;
  logic             consume_s;

  assign accept_s  = LOAD_VALID && (state_q == pattern_pkg::IDLE);
  assign consume_s = SHIFT_EN && (state_q == pattern_pkg::SHIFT);

  // Next state; serial outputs are computed one edge ahead so they come out registered
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    idx_d    = idx_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    done_d   = 1'b0;
    case (state_q)
      pattern_pkg::IDLE: begin
        dout_d   = 1'b0;
        dvalid_d = 1'b0;
        if (accept_s) begin
          state_d  = pattern_pkg::SHIFT;
          sreg_d   = LOAD_DATA;
          idx_d    = {IDXW{1'b0}};
          dout_d   = LOAD_DATA[0];
          dvalid_d = 1'b1;
        end else begin
          state_d = pattern_pkg::IDLE;
        end
      end
      pattern_pkg::SHIFT: begin
        if (consume_s) begin
          sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
          idx_d  = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            state_d  = pattern_pkg::DONE;
            dout_d   = 1'b0;
            dvalid_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            dout_d   = sreg_q[1];
            dvalid_d = 1'b1;
          end
        end else begin
          state_d = pattern_pkg::SHIFT;
        end
      end
      pattern_pkg::DONE: begin
        state_d  = pattern_pkg::IDLE;
        dout_d   = 1'b0;
        dvalid_d = 1'b0;
      end
      default: begin
        state_d  = pattern_pkg::IDLE;
        dout_d   = 1'b0;
        dvalid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= pattern_pkg::IDLE;
      sreg_q   <= {WIDTH{1'b0}};
      idx_q    <= {IDXW{1'b0}};
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      idx_q    <= idx_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      done_q   <= done_d;
    end
  end

  pattern_match_counter #(
    .CNTW(CNTW)
  ) u_counter (
    .clk        (clk),
    .rst_n      (reset),
    .bit_i      (sreg_q[0]),
    .bit_valid_i(consume_s),
    .clear_i    (accept_s),
    .count_o    (MATCH_COUNT)
  );

  assign LOAD_READY = (state_q == pattern_pkg::IDLE);
  assign DOUT       = dout_q;
  assign DOUT_VALID = dvalid_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: a queue-based reference of the emitted
// stream plus a sliding-window match count over the loaded word.
module tb_pattern_tx;

  localparam int W  = 23;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic [W-1:0]  load_data = '0;
  logic          load_ready;
  logic          shift_en = 1'b0;
  logic          dout;
  logic          dout_valid;
  logic          done;
  logic [CW-1:0] match_count;

  int total = 0;
  int bad = 0;

  pattern_tx #(.WIDTH(W), .CNTW(CW)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .LOAD_VALID (load_valid),
    .LOAD_DATA  (load_data),
    .LOAD_READY (load_ready),
    .SHIFT_EN   (shift_en),
    .DOUT       (dout),
    .DOUT_VALID (dout_valid),
    .DONE       (done),
    .MATCH_COUNT(match_count)
  );

  always #5 clk = ~clk;

  // Overlapping 1,0,1,1 occurrences in LSB-first order, saturating.
  function automatic int ref_count(input logic [W-1:0] w);
    int c = 0;
    for (int i = 3; i < W; i++)
      if (w[i-3] && !w[i-2] && w[i-1] && w[i]) c++;
    if (c > (1 << CW) - 1) c = (1 << CW) - 1;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after an accept; returns the cycle (relative to
  // the accept edge) in which DONE was seen, or -1. Ends in the next IDLE cycle.
  task automatic stream_check(input logic [W-1:0] word, input int mode,
                              input string name, output int done_cyc);
    logic q[$];
    int   lows;
    int   exp_cnt;
    logic en;
    lows = 0;
    done_cyc = -1;
    exp_cnt = ref_count(word);
    for (int i = 0; i < W; i++) q.push_back(word[i]);
    for (int cyc = 1; cyc < 200; cyc++) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = cyc[0];
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      shift_en = en;
      if (q.size() > 0) begin
        total++;
        if (dout !== q[0] || dout_valid !== 1'b1 || done !== 1'b0 || load_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s_bit c%0d: dout=%b valid=%b done=%b ready=%b, want dout=%b valid=1 done=0 ready=0",
                   name, cyc, dout, dout_valid, done, load_ready, q[0]);
        end
        if (en) void'(q.pop_front());
        else lows++;
      end else begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
    total++;
    if (done_cyc < 0) begin
      bad++;
      $display("FAIL %s_timeout: done never seen, want it after %0d cycles", name, 1 + W + lows);
    end else begin
      if (done !== 1'b1 || dout_valid !== 1'b0 || dout !== 1'b0 || done_cyc != 1 + W + lows) begin
        bad++;
        $display("FAIL %s_done: done=%b valid=%b dout=%b at c%0d, want done=1 valid=0 dout=0 at c%0d",
                 name, done, dout_valid, dout, done_cyc, 1 + W + lows);
      end
      total++;
      if (match_count !== CW'(exp_cnt)) begin
        bad++;
        $display("FAIL %s_count: got %0d want %0d", name, match_count, exp_cnt);
      end
    end
    tick();
    total++;
    if (load_ready !== 1'b1 || done !== 1'b0 || dout !== 1'b0 || dout_valid !== 1'b0 ||
        match_count !== CW'(exp_cnt)) begin
      bad++;
      $display("FAIL %s_idle: ready=%b done=%b dout=%b valid=%b count=%0d, want 1 0 0 0 %0d",
               name, load_ready, done, dout, dout_valid, match_count, exp_cnt);
    end
  endtask

  task automatic send(input logic [W-1:0] word, input int mode, input string name,
                      output int done_cyc);
    load_valid = 1'b1;
    load_data  = word;
    tick();
    load_valid = 1'b0;
    load_data  = W'($urandom);
    stream_check(word, mode, name, done_cyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (load_ready !== 1'b1 || dout !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0 ||
        match_count !== '0) begin
      bad++;
      $display("FAIL reset: ready=%b dout=%b valid=%b done=%b count=%0d, want 1 0 0 0 0",
               load_ready, dout, dout_valid, done, match_count);
    end
  endtask

  task automatic test_known();
    int dc;
    send(23'h59D8DB, 0, "known59", dc);
    total++;
    if (dc != 24 || match_count !== 5'd3) begin
      bad++;
      $display("FAIL known59_spec: done at %0d count=%0d, want 24 and 3", dc, match_count);
    end
    send(23'h00006D, 0, "known6d", dc);
    total++;
    if (match_count !== 5'd2) begin
      bad++;
      $display("FAIL known6d_overlap: count=%0d want 2", match_count);
    end
  endtask

  task automatic test_stall();
    int dc;
    send(23'h00006D, 1, "stall", dc);
    total++;
    if (dc != 46 || match_count !== 5'd2) begin
      bad++;
      $display("FAIL stall_timing: done at %0d count=%0d, want 46 and 2", dc, match_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    int dc;
    a = W'($urandom);
    b = ~a;
    load_valid = 1'b1;
    load_data  = a;
    tick();
    load_data = b;
    stream_check(a, 0, "b2b_first", dc);
    tick();
    load_valid = 1'b0;
    stream_check(b, 0, "b2b_second", dc);
    total++;
    if (dc != 24) begin
      bad++;
      $display("FAIL b2b_spacing: second done at %0d want 24", dc);
    end
  endtask

  task automatic test_midword_reset();
    logic [W-1:0] w;
    int dc;
    w = W'($urandom) | 23'h000400;
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
    shift_en   = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (dout !== w[10] || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: dout=%b valid=%b want %b 1", dout, dout_valid, w[10]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (load_ready !== 1'b1 || dout !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0 ||
        match_count !== '0) begin
      bad++;
      $display("FAIL rst_mid: ready=%b dout=%b valid=%b done=%b count=%0d, want 1 0 0 0 0",
               load_ready, dout, dout_valid, done, match_count);
    end
    tick();
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL rst_nodone: done=%b want 0", done);
    end
    rst_n = 1'b1;
    tick();
    send(23'h2D6B5B, 0, "rst_after", dc);
  endtask

  task automatic test_random();
    int dc;
    for (int n = 0; n < 8; n++) begin
      send(W'($urandom), n % 3, "rand", dc);
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_stall();
    test_back_to_back();
    test_midword_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
